uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter. It is the outbound counterpart of the existing UART receive path in impl_top. It accepts one payload word per valid/ready handshake and serialises it onto uart_txd, LSB first, as one frame: start bit, data bits, optional parity bit, then stop bit(s). impl_top instances it to echo and report register values back to the host, at the same BIT_RATE and CLK_HZ as the receiver.

Parameters:
BIT_RATE, 9600, line bit rate in bits/s.
CLK_HZ, 50000000, clk frequency in Hz.
PAYLOAD_BITS, 8, data bits per frame; legal range 5..9.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
reset  in  1  synchronous reset, active-high.
tx_valid  in  1  tx_data is valid and requests transmission.
tx_ready  out  1  block can accept a word this cycle.
tx_data  in  PAYLOAD_BITS  word to send.
uart_txd  out  1  serial line output, idle high.
tx_busy  out  1  a frame is in progress (state not IDLE).

Behaviour:
- Timing: CYCLES_PER_BIT = CLK_HZ / BIT_RATE, using truncating integer division (5208 at defaults). Bit counter width = clog2(CYCLES_PER_BIT + 1).
- All outputs are registered.
- Reset values: uart_txd = 1, tx_ready = 0, tx_busy = 0, state = IDLE, counters = 0.
- tx_ready goes to 1 on the first cycle after reset is deasserted.
- Handshake: a word is accepted on a rising edge where tx_valid && tx_ready. On that edge:
  - tx_data is latched into the shift register.
  - tx_ready goes to 0 and tx_busy goes to 1.
  - state moves to START and uart_txd goes to 0, all in the following cycle.
- tx_valid while tx_ready = 0 is ignored, and the data is not latched. The caller holds data until accepted.
- State machine is IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - PARITY is skipped when PARITY = 0.
  - Each bit is held for exactly CYCLES_PER_BIT cycles.
  - DATA emits bit 0 first and shifts right once per bit. A bit index from 0 to PAYLOAD_BITS-1 selects the transition to the next state.
  - The parity bit is computed from the latched word. Odd mode: ~^data. Even mode: ^data.
  - STOP drives 1 for STOP_BITS * CYCLES_PER_BIT cycles.
- Frame length: (1 + PAYLOAD_BITS + (PARITY != 0) + STOP_BITS) * CYCLES_PER_BIT cycles, measured from the first 0 on uart_txd to the return to IDLE.
- Return to IDLE: on the edge that ends the last stop cycle, tx_ready goes to 1 and tx_busy goes to 0.
- Back-to-back frames: with tx_valid held high, the next word is accepted in the first IDLE cycle. The line therefore has exactly one extra idle-high cycle between frames. This gap is required and checked.
- Reset mid-frame: on the next edge uart_txd = 1, state = IDLE, and tx_ready = 0 for that cycle. The partial frame is abandoned and not resumed.
- Reset takes priority over the handshake in the same cycle.
- Illegal parameters (PAYLOAD_BITS outside 5..9, STOP_BITS not 1 or 2, PARITY > 2, or CYCLES_PER_BIT < 2) cause an elaboration-time error via a generate-time check.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants (IDLE, START, DATA, PARITY, STOP; 3 bits);
  - parity mode constants PARITY_NONE, PARITY_ODD, PARITY_EVEN;
  - a cycles_per_bit(clk_hz, bit_rate) function, also reused by the receiver.
- One natural sub-module: uart_bit_timer.
  - Inputs: clk, reset, restart.
  - Output: a one-cycle bit_done pulse every CYCLES_PER_BIT cycles.
  - The FSM and shift register stay in uart_tx.

Test Plan:
- Reset, defaults: hold reset for 4 cycles, then release. Required: uart_txd = 1 and tx_ready = 0 throughout reset, and tx_ready = 1 on the first cycle after release.
- Send 0x41 ('A') at defaults: sample uart_txd at each mid-bit (offset 2604 cycles, then steps of 5208). Required sequence: 0,1,0,0,0,0,0,1,0,1. Also required: tx_busy high for 52080 cycles and tx_ready low for the same span.
- Back-to-back frames: tx_valid held with 0x00, then 0xFF. Required: the second start bit begins exactly 1 cycle after the first frame's stop bit ends, and the sampled bits match both words.
- Parity and stop bits: PARITY = 2, STOP_BITS = 2, send 0x07. Required: parity bit = 1 and the line high for 2*CYCLES_PER_BIT cycles before IDLE. With PARITY = 1, the same word gives parity bit = 0.
- Reset mid-frame: assert reset during data bit 3 of 0x55. Required: uart_txd = 1 on the next edge. A subsequent send of 0xA5 must transmit cleanly with no residue from 0x55.
- Ignored request: pulse tx_valid with 0x12 while tx_busy = 1. Required: the pulse has no effect, and the frame in flight completes unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and bit-timing helper.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4
   } uart_state_e;

   localparam int unsigned ParityNone = 0;
   localparam int unsigned ParityOdd  = 1;
   localparam int unsigned ParityEven = 2;

   // Truncating division; the receiver derives its sampling period the same way.
   function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                  input int unsigned bit_rate);
      return clk_hz / bit_rate;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: pulses bit_done on the last cycle of every bit period.
module uart_bit_timer #(
   parameter int unsigned CYCLES_PER_BIT = 5208
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic bit_done
);

   localparam int unsigned CntW = $clog2(CYCLES_PER_BIT + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(CYCLES_PER_BIT - 1);

   logic [CntW-1:0] r_cnt;

   // Held at zero while restart is high so the first bit starts a full period.
   always_ff @(posedge clk) begin
      if (reset || restart) begin
         r_cnt <= '0;
      end else if (r_cnt == CntLast) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CntW'(1);
      end
   end

   assign bit_done = (r_cnt == CntLast);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word in, LSB-first framed serial stream out.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned BIT_RATE     = 9600,
   parameter int unsigned CLK_HZ       = 50000000,
   parameter int unsigned PAYLOAD_BITS = 8,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned PARITY       = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    tx_valid,
   output logic                    tx_ready,
   input  logic [PAYLOAD_BITS-1:0] tx_data,
   output logic                    uart_txd,
   output logic                    tx_busy
);

   localparam int unsigned CyclesPerBit = cycles_per_bit(CLK_HZ, BIT_RATE);
   localparam int unsigned IdxW = 4;
   localparam logic [IdxW-1:0] LastDataIdx = IdxW'(PAYLOAD_BITS - 1);
   localparam logic [IdxW-1:0] LastStopIdx = IdxW'(STOP_BITS - 1);

   if (PAYLOAD_BITS < 5 || PAYLOAD_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
       PARITY > 2 || CyclesPerBit < 2) begin : g_param_check
      $error("uart_tx: illegal parameter combination");
   end

   uart_state_e             r_state, w_state_nxt;
   logic [PAYLOAD_BITS-1:0] r_shift, w_shift_nxt;
   logic [IdxW-1:0]         r_idx, w_idx_nxt;
   logic                    r_par, w_par_nxt;
   logic                    r_txd, w_txd_nxt;
   logic                    r_ready, w_ready_nxt;
   logic                    r_busy, w_busy_nxt;
   logic                    w_accept;
   logic                    w_restart;
   logic                    w_bit_done;

   assign w_accept  = tx_valid && r_ready;
   assign w_restart = (r_state == StIdle);

   uart_bit_timer #(
      .CYCLES_PER_BIT(CyclesPerBit)
   ) u_bit_timer (
      .clk     (clk),
      .reset   (reset),
      .restart (w_restart),
      .bit_done(w_bit_done)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_idx_nxt   = r_idx;
      w_par_nxt   = r_par;
      w_txd_nxt   = r_txd;
      w_ready_nxt = r_ready;
      w_busy_nxt  = r_busy;
      case (r_state)
         StIdle: begin
            w_txd_nxt   = 1'b1;
            w_ready_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
            if (w_accept) begin
               w_state_nxt = StStart;
               w_shift_nxt = tx_data;
               w_par_nxt   = (PARITY == ParityOdd) ? ~^tx_data : ^tx_data;
               w_idx_nxt   = '0;
               w_txd_nxt   = 1'b0;
               w_ready_nxt = 1'b0;
               w_busy_nxt  = 1'b1;
            end
         end
         StStart: begin
            if (w_bit_done) begin
               w_state_nxt = StData;
               w_txd_nxt   = r_shift[0];
               w_shift_nxt = r_shift >> 1;
               w_idx_nxt   = '0;
            end
         end
         StData: begin
            if (w_bit_done) begin
               if (r_idx == LastDataIdx) begin
                  w_idx_nxt = '0;
                  if (PARITY == ParityNone) begin
                     w_state_nxt = StStop;
                     w_txd_nxt   = 1'b1;
                  end else begin
                     w_state_nxt = StParity;
                     w_txd_nxt   = r_par;
                  end
               end else begin
                  w_idx_nxt   = r_idx + IdxW'(1);
                  w_txd_nxt   = r_shift[0];
                  w_shift_nxt = r_shift >> 1;
               end
            end
         end
         StParity: begin
            if (w_bit_done) begin
               w_state_nxt = StStop;
               w_txd_nxt   = 1'b1;
               w_idx_nxt   = '0;
            end
         end
         StStop: begin
            // Stop bits reuse the bit index to count whole bit periods.
            if (w_bit_done) begin
               if (r_idx == LastStopIdx) begin
                  w_state_nxt = StIdle;
                  w_ready_nxt = 1'b1;
                  w_busy_nxt  = 1'b0;
               end else begin
                  w_idx_nxt = r_idx + IdxW'(1);
               end
            end
         end
         default: begin
            w_state_nxt = StIdle;
            w_txd_nxt   = 1'b1;
            w_ready_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
         r_shift <= '0;
         r_idx   <= '0;
         r_par   <= 1'b0;
         r_txd   <= 1'b1;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_idx   <= w_idx_nxt;
         r_par   <= w_par_nxt;
         r_txd   <= w_txd_nxt;
         r_ready <= w_ready_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   assign uart_txd = r_txd;
   assign tx_ready = r_ready;
   assign tx_busy  = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: one default instance plus three fast-baud parity/stop variants.
module tb_uart_tx;

   localparam int unsigned FastHz   = 1600;
   localparam int unsigned FastRate = 100;
   localparam int unsigned FastCpb  = FastHz / FastRate;
   localparam int          CapMax   = 60000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       valid [4];
   logic [7:0] data  [4];
   logic       txd   [4];
   logic       ready [4];
   logic       busy  [4];

   int n_err    = 0;
   int n_checks = 0;

   logic cap_txd   [CapMax];
   logic cap_busy  [CapMax];
   logic cap_ready [CapMax];
   logic exp_bits  [16];
   logic exp_prev  [16];

   uart_tx u_def (
      .clk(clk), .reset(reset), .tx_valid(valid[0]), .tx_ready(ready[0]),
      .tx_data(data[0]), .uart_txd(txd[0]), .tx_busy(busy[0])
   );
   uart_tx #(.BIT_RATE(FastRate), .CLK_HZ(FastHz)) u_none (
      .clk(clk), .reset(reset), .tx_valid(valid[1]), .tx_ready(ready[1]),
      .tx_data(data[1]), .uart_txd(txd[1]), .tx_busy(busy[1])
   );
   uart_tx #(.BIT_RATE(FastRate), .CLK_HZ(FastHz), .STOP_BITS(2), .PARITY(2)) u_even (
      .clk(clk), .reset(reset), .tx_valid(valid[2]), .tx_ready(ready[2]),
      .tx_data(data[2]), .uart_txd(txd[2]), .tx_busy(busy[2])
   );
   uart_tx #(.BIT_RATE(FastRate), .CLK_HZ(FastHz), .PARITY(1)) u_odd (
      .clk(clk), .reset(reset), .tx_valid(valid[3]), .tx_ready(ready[3]),
      .tx_data(data[3]), .uart_txd(txd[3]), .tx_busy(busy[3])
   );

   function automatic int cpb_of(input int k);
      return (k == 0) ? 5208 : int'(FastCpb);
   endfunction

   function automatic int par_of(input int k);
      return (k == 2) ? 2 : ((k == 3) ? 1 : 0);
   endfunction

   function automatic int stops_of(input int k);
      return (k == 2) ? 2 : 1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference frame as a list of line levels, one per bit period.
   task automatic model_frame(input int k, input logic [7:0] w, output int nb);
      int ones;
      ones = 0;
      nb = 0;
      exp_bits[nb] = 1'b0;
      nb = nb + 1;
      for (int b = 0; b < 8; b++) begin
         exp_bits[nb] = w[b];
         nb = nb + 1;
         ones = ones + int'(w[b]);
      end
      if (par_of(k) == 1) begin
         exp_bits[nb] = (ones % 2 == 0);
         nb = nb + 1;
      end else if (par_of(k) == 2) begin
         exp_bits[nb] = (ones % 2 == 1);
         nb = nb + 1;
      end
      for (int s = 0; s < stops_of(k); s++) begin
         exp_bits[nb] = 1'b1;
         nb = nb + 1;
      end
   endtask

   // Index 0 of the capture is the first cycle the line shows the start bit.
   task automatic capture(input int k, input logic [7:0] w1, input logic [7:0] w2,
                          input int len, input int drop_at, input int poke_at,
                          output bit ok);
      ok = 1'b0;
      valid[k] = 1'b1;
      data[k]  = w1;
      for (int t = 0; t < 4 * cpb_of(k) + 8 && !ok; t++) begin
         step();
         if (txd[k] === 1'b0) ok = 1'b1;
      end
      if (!ok) begin
         valid[k] = 1'b0;
         return;
      end
      for (int i = 0; i < len; i++) begin
         if (i > 0) step();
         cap_txd[i]   = txd[k];
         cap_busy[i]  = busy[k];
         cap_ready[i] = ready[k];
         if (i == 0) data[k] = w2;
         if (i == drop_at) valid[k] = 1'b0;
         if (poke_at >= 0 && i == poke_at) begin
            valid[k] = 1'b1;
            data[k]  = 8'h12;
         end else if (poke_at >= 0 && i == poke_at + 1) begin
            valid[k] = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if (txd[0] !== 1'b1 || ready[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold cycle %0d: txd=%b ready=%b, required txd=1 ready=0",
                     i, txd[0], ready[0]);
         end
      end
      reset = 1'b0;
      step();
      n_checks++;
      if (ready[0] !== 1'b1 || busy[0] !== 1'b0 || txd[0] !== 1'b1) begin
         n_err++;
         $display("FAIL reset_release: ready=%b busy=%b txd=%b, required 1 0 1",
                  ready[0], busy[0], txd[0]);
      end
      n_checks++;
      if (ready[1] !== 1'b1 || ready[2] !== 1'b1 || ready[3] !== 1'b1) begin
         n_err++;
         $display("FAIL reset_release_fast: ready=%b%b%b, required 111",
                  ready[1], ready[2], ready[3]);
      end
   endtask

   task automatic test_default_frame();
      bit   ok;
      int   nb, fl, cpb, bc, rc, bad;
      logic e;
      cpb = cpb_of(0);
      model_frame(0, 8'h41, nb);
      fl = nb * cpb;
      capture(0, 8'h41, 8'h41, fl + 3, 0, -1, ok);
      n_checks++;
      if (!ok) begin
         n_err++;
         $display("FAIL default_start: no start bit seen, required one");
         return;
      end
      for (int b = 0; b < nb; b++) begin
         n_checks++;
         if (cap_txd[b * cpb + cpb / 2] !== exp_bits[b]) begin
            n_err++;
            $display("FAIL default_midbit %0d: got %b, required %b",
                     b, cap_txd[b * cpb + cpb / 2], exp_bits[b]);
         end
      end
      bc = 0; rc = 0; bad = 0;
      for (int i = 0; i < fl + 3; i++) begin
         if (cap_busy[i] === 1'b1) bc++;
         if (cap_ready[i] === 1'b0) rc++;
         e = (i < fl) ? exp_bits[i / cpb] : 1'b1;
         if (cap_txd[i] !== e) bad++;
      end
      n_checks++;
      if (bc != fl) begin
         n_err++;
         $display("FAIL default_busy_span: got %0d cycles, required %0d", bc, fl);
      end
      n_checks++;
      if (rc != fl) begin
         n_err++;
         $display("FAIL default_ready_low_span: got %0d cycles, required %0d", rc, fl);
      end
      n_checks++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL default_line_cycles: %0d wrong cycles, required 0", bad);
      end
      n_checks++;
      if (cap_busy[fl] !== 1'b0 || cap_ready[fl] !== 1'b1) begin
         n_err++;
         $display("FAIL default_return_idle: busy=%b ready=%b, required 0 1",
                  cap_busy[fl], cap_ready[fl]);
      end
   endtask

   task automatic test_random_frames();
      bit         ok;
      int         nb, fl, cpb, bad;
      logic       e;
      logic [7:0] w;
      cpb = cpb_of(1);
      for (int n = 0; n < 6; n++) begin
         w = 8'($urandom_range(0, 255));
         model_frame(1, w, nb);
         fl = nb * cpb;
         capture(1, w, w, fl + 2, 0, -1, ok);
         n_checks++;
         if (!ok) begin
            n_err++;
            $display("FAIL random_start word %h: no start bit, required one", w);
            continue;
         end
         bad = 0;
         for (int i = 0; i < fl + 2; i++) begin
            e = (i < fl) ? exp_bits[i / cpb] : 1'b1;
            if (cap_txd[i] !== e || cap_busy[i] !== (i < fl)) bad++;
         end
         n_checks++;
         if (bad != 0) begin
            n_err++;
            $display("FAIL random_frame word %h: %0d wrong cycles, required 0", w, bad);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit         ok;
      int         nb, fl, cpb, bad;
      logic       e;
      logic [7:0] w1, w2;
      cpb = cpb_of(1);
      for (int n = 0; n < 2; n++) begin
         w1 = (n == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         w2 = (n == 0) ? 8'hFF : 8'($urandom_range(0, 255));
         model_frame(1, w1, nb);
         for (int b = 0; b < 16; b++) exp_prev[b] = exp_bits[b];
         fl = nb * cpb;
         model_frame(1, w2, nb);
         capture(1, w1, w2, 2 * fl + 4, fl + 1, -1, ok);
         n_checks++;
         if (!ok) begin
            n_err++;
            $display("FAIL b2b_start pair %0d: no start bit, required one", n);
            continue;
         end
         n_checks++;
         if (cap_txd[fl - 1] !== 1'b1 || cap_txd[fl] !== 1'b1 || cap_txd[fl + 1] !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_gap pair %0d: line %b%b%b around gap, required 110",
                     n, cap_txd[fl - 1], cap_txd[fl], cap_txd[fl + 1]);
         end
         bad = 0;
         for (int i = 0; i < 2 * fl + 4; i++) begin
            if (i < fl) e = exp_prev[i / cpb];
            else if (i == fl) e = 1'b1;
            else if (i <= 2 * fl) e = exp_bits[(i - fl - 1) / cpb];
            else e = 1'b1;
            if (cap_txd[i] !== e) bad++;
         end
         n_checks++;
         if (bad != 0) begin
            n_err++;
            $display("FAIL b2b_frames %h/%h: %0d wrong cycles, required 0", w1, w2, bad);
         end
         n_checks++;
         if (cap_ready[fl] !== 1'b1 || cap_busy[2 * fl + 1] !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_handshake: gap ready=%b end busy=%b, required 1 0",
                     cap_ready[fl], cap_busy[2 * fl + 1]);
         end
      end
   endtask

   task automatic test_parity_stop();
      bit         ok;
      int         nb, fl, cpb, bad, k;
      logic       e, par_req;
      logic [7:0] w;
      cpb = cpb_of(2);
      for (int m = 0; m < 6; m++) begin
         k = (m < 3) ? 2 : 3;
         w = (m % 3 == 0) ? 8'h07 : 8'($urandom_range(0, 255));
         model_frame(k, w, nb);
         fl = nb * cpb;
         capture(k, w, w, fl + 2, 0, -1, ok);
         n_checks++;
         if (!ok) begin
            n_err++;
            $display("FAIL parity_start k=%0d word %h: no start bit, required one", k, w);
            continue;
         end
         if (w == 8'h07 && m % 3 == 0) begin
            par_req = (k == 2) ? 1'b1 : 1'b0;
            n_checks++;
            if (cap_txd[9 * cpb + cpb / 2] !== par_req) begin
               n_err++;
               $display("FAIL parity_bit k=%0d: got %b, required %b",
                        k, cap_txd[9 * cpb + cpb / 2], par_req);
            end
            bad = 0;
            for (int i = 10 * cpb; i < fl; i++) if (cap_txd[i] !== 1'b1) bad++;
            n_checks++;
            if (bad != 0 || cap_busy[fl - 1] !== 1'b1 || cap_busy[fl] !== 1'b0) begin
               n_err++;
               $display("FAIL stop_span k=%0d: %0d low stop cycles, busy end %b%b, required 0 10",
                        k, bad, cap_busy[fl - 1], cap_busy[fl]);
            end
         end
         bad = 0;
         for (int i = 0; i < fl + 2; i++) begin
            e = (i < fl) ? exp_bits[i / cpb] : 1'b1;
            if (cap_txd[i] !== e) bad++;
         end
         n_checks++;
         if (bad != 0) begin
            n_err++;
            $display("FAIL parity_frame k=%0d word %h: %0d wrong cycles, required 0", k, w, bad);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      bit   ok;
      int   nb, fl, cpb, bad, mid3;
      logic e;
      cpb  = cpb_of(1);
      mid3 = 4 * cpb + cpb / 2;
      capture(1, 8'h55, 8'h55, mid3 + 1, 0, -1, ok);
      n_checks++;
      if (!ok || cap_txd[mid3] !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_setup: started=%0d bit3=%b, required 1 0", ok, cap_txd[mid3]);
      end
      reset = 1'b1;
      step();
      n_checks++;
      if (txd[1] !== 1'b1 || ready[1] !== 1'b0 || busy[1] !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_edge: txd=%b ready=%b busy=%b, required 1 0 0",
                  txd[1], ready[1], busy[1]);
      end
      reset = 1'b0;
      step();
      n_checks++;
      if (ready[1] !== 1'b1 || txd[1] !== 1'b1) begin
         n_err++;
         $display("FAIL rst_mid_release: ready=%b txd=%b, required 1 1", ready[1], txd[1]);
      end
      model_frame(1, 8'hA5, nb);
      fl = nb * cpb;
      capture(1, 8'hA5, 8'hA5, fl + 2, 0, -1, ok);
      bad = 0;
      for (int i = 0; i < fl + 2; i++) begin
         e = (i < fl) ? exp_bits[i / cpb] : 1'b1;
         if (cap_txd[i] !== e) bad++;
      end
      n_checks++;
      if (!ok || bad != 0) begin
         n_err++;
         $display("FAIL rst_mid_resend: started=%0d wrong cycles=%0d, required 1 0", ok, bad);
      end
   endtask

   task automatic test_ignored_request();
      bit         ok;
      int         nb, fl, cpb, bad;
      logic       e;
      logic [7:0] w;
      cpb = cpb_of(1);
      w = 8'($urandom_range(0, 255));
      model_frame(1, w, nb);
      fl = nb * cpb;
      capture(1, w, w, fl + 2 * cpb, 0, 3 * cpb, ok);
      n_checks++;
      if (!ok) begin
         n_err++;
         $display("FAIL ignored_start: no start bit, required one");
         return;
      end
      bad = 0;
      for (int i = 0; i < fl + 2 * cpb; i++) begin
         e = (i < fl) ? exp_bits[i / cpb] : 1'b1;
         if (cap_txd[i] !== e || cap_busy[i] !== (i < fl)) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL ignored_request word %h: %0d wrong cycles, required 0", w, bad);
      end
      n_checks++;
      if (cap_ready[fl + 2 * cpb - 1] !== 1'b1) begin
         n_err++;
         $display("FAIL ignored_idle_ready: got %b, required 1", cap_ready[fl + 2 * cpb - 1]);
      end
   endtask

   initial begin
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         valid[k] = 1'b0;
         data[k]  = 8'h00;
      end
      test_reset();
      test_default_frame();
      test_random_frames();
      test_back_to_back();
      test_parity_stop();
      test_reset_mid_frame();
      test_ignored_request();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
